// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared ALU opcode bus definitions and memory-op decode helpers
// for the load/store unit.
package lsu_mem_ctrl_pkg;

    localparam int ALU_OP_W = 8;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [ALU_OP_W-1:0] ALU_OP_LB  = 8'h20;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LH  = 8'h21;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LW  = 8'h22;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LBU = 8'h24;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LHU = 8'h25;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SB  = 8'h28;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SH  = 8'h29;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SW  = 8'h2A;

    typedef enum logic [1:0] {
        MEM_NONE,
        MEM_BYTE,
        MEM_HALF,
        MEM_WORD
    } mem_size_e;

    function automatic mem_size_e op_size(input logic [ALU_OP_W-1:0] op);
        mem_size_e sz;
        case (op)
            ALU_OP_LB, ALU_OP_LBU, ALU_OP_SB: sz = MEM_BYTE;
            ALU_OP_LH, ALU_OP_LHU, ALU_OP_SH: sz = MEM_HALF;
            ALU_OP_LW, ALU_OP_SW:             sz = MEM_WORD;
            default:                          sz = MEM_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic op_is_store(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_OP_SB) || (op == ALU_OP_SH) || (op == ALU_OP_SW);
    endfunction

    function automatic logic op_is_load(input logic [ALU_OP_W-1:0] op);
        return (op_size(op) != MEM_NONE) && !op_is_store(op);
    endfunction

    function automatic logic op_misaligned(input logic [ALU_OP_W-1:0] op,
                                           input logic [1:0] off);
        logic bad;
        case (op_size(op))
            MEM_HALF: bad = off[0];
            MEM_WORD: bad = (off != 2'b00);
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_store_align.sv
// Store lane steering: byte strobes and replicated write data
// derived from the opcode and the low address bits.
module store_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op_i,
    input  logic [1:0]          offset_i,
    input  logic [31:0]         wdata_i,
    output logic [3:0]          wstrb_o,
    output logic [31:0]         wdata_o
);

    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = ZERO_WORD;
        if (op_is_store(alu_op_i)) begin
            case (op_size(alu_op_i))
                MEM_BYTE: begin
                    wstrb_o = 4'b0001 << offset_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                MEM_HALF: begin
                    wstrb_o = 4'b0011 << offset_i;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                MEM_WORD: begin
                    wstrb_o = 4'b1111;
                    wdata_o = wdata_i;
                end
                default: begin
                    wstrb_o = 4'b0000;
                    wdata_o = ZERO_WORD;
                end
            endcase
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: accepts one op from execute,
// runs the data-memory handshake and holds the result for writeback.
module lsu_mem_ctrl #(
    parameter int ALU_OP_W = lsu_mem_ctrl_pkg::ALU_OP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid_i,
    output logic                ex_ready_o,
    input  logic [ALU_OP_W-1:0] alu_op_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    output logic [3:0]          mem_wstrb_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [31:0]         mem_rdata_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [31:0]         read_offset_o,
    output logic [31:0]         rmem_data_o,
    output logic                misalign_o
);

    import lsu_mem_ctrl_pkg::*;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    state_e              state_q;
    logic [ALU_OP_W-1:0] op_q;
    logic [31:0]         addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                mem_req_q;
    logic                wb_valid_q;
    logic                misal_q;

    logic accept;
    logic is_mem;
    logic bad;

    assign ex_ready_o = (state_q == IDLE) || ((state_q == DONE) && wb_ready_i);
    assign accept     = ex_valid_i && ex_ready_o;
    assign is_mem     = op_size(alu_op_i) != MEM_NONE;
    assign bad        = is_mem && op_misaligned(alu_op_i, addr_i[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            addr_q     <= ZERO_WORD;
            wdata_q    <= ZERO_WORD;
            rdata_q    <= ZERO_WORD;
            mem_req_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            misal_q    <= 1'b0;
        end else begin
            case (state_q)
                REQ: if (mem_gnt_i) begin
                    state_q   <= WAIT;
                    mem_req_q <= 1'b0;
                end
                WAIT: if (mem_rvalid_i) begin
                    state_q    <= DONE;
                    wb_valid_q <= 1'b1;
                    if (op_is_load(op_q)) rdata_q <= mem_rdata_i;
                end
                DONE: if (wb_ready_i && !ex_valid_i) begin
                    state_q    <= IDLE;
                    wb_valid_q <= 1'b0;
                    misal_q    <= 1'b0;
                end
                default: ;
            endcase
            // A new op overrides whatever the retiring op scheduled above
            if (accept) begin
                op_q    <= alu_op_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                rdata_q <= ZERO_WORD;
                misal_q <= bad;
                if (is_mem && !bad) begin
                    state_q    <= REQ;
                    mem_req_q  <= 1'b1;
                    wb_valid_q <= 1'b0;
                end else begin
                    state_q    <= DONE;
                    mem_req_q  <= 1'b0;
                    wb_valid_q <= 1'b1;
                end
            end
        end
    end

    store_align u_store_align (
        .alu_op_i (op_q),
        .offset_i (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .wstrb_o  (mem_wstrb_o),
        .wdata_o  (mem_wdata_o)
    );

    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = op_is_store(op_q);
    assign mem_addr_o    = {addr_q[31:2], 2'b00};
    assign wb_valid_o    = wb_valid_q;
    assign alu_op_o      = op_q;
    assign read_offset_o = {30'b0, addr_q[1:0]};
    assign rmem_data_o   = rdata_q;
    assign misalign_o    = misal_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed scenarios with literal expectations
// plus a random run against a transaction-level reference model.
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic [7:0]  alu_op_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [7:0]  alu_op_o;
    logic [31:0] read_offset_o, rmem_data_o;
    logic        misalign_o;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ALU_OP_W(8)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .alu_op_i(alu_op_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .alu_op_o(alu_op_o), .read_offset_o(read_offset_o),
        .rmem_data_o(rmem_data_o), .misalign_o(misalign_o)
    );

    // Reference model: one transaction record and its progress flags
    bit          m_have, m_granted, m_resp;
    logic [7:0]  m_op;
    logic [31:0] m_addr, m_wdata, m_got;

    function automatic bit is_load(input logic [7:0] op);
        return op == ALU_OP_LB || op == ALU_OP_LH || op == ALU_OP_LW ||
               op == ALU_OP_LBU || op == ALU_OP_LHU;
    endfunction

    function automatic bit is_store(input logic [7:0] op);
        return op == ALU_OP_SB || op == ALU_OP_SH || op == ALU_OP_SW;
    endfunction

    function automatic bit misal(input logic [7:0] op, input logic [31:0] a);
        bit half, word;
        half = op == ALU_OP_LH || op == ALU_OP_LHU || op == ALU_OP_SH;
        word = op == ALU_OP_LW || op == ALU_OP_SW;
        return (half && a[0]) || (word && a[1:0] != 2'd0);
    endfunction

    function automatic bit needs_mem(input logic [7:0] op, input logic [31:0] a);
        return (is_load(op) || is_store(op)) && !misal(op, a);
    endfunction

    function automatic logic [3:0] exp_strb(input logic [7:0] op, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (op == ALU_OP_SB) return 4'(1 << off);
        if (op == ALU_OP_SH) return 4'(3 << off);
        if (op == ALU_OP_SW) return 4'd15;
        return 4'd0;
    endfunction

    function automatic logic [31:0] exp_data(input logic [7:0] op, input logic [31:0] d);
        if (op == ALU_OP_SB) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (op == ALU_OP_SH) return {16'd0, d[15:0]} * 32'h0001_0001;
        if (op == ALU_OP_SW) return d;
        return 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_req();
        return m_have && needs_mem(m_op, m_addr) && !m_granted;
    endfunction

    function automatic bit m_wbv();
        return m_have && (!needs_mem(m_op, m_addr) || m_resp);
    endfunction

    task automatic model_reset();
        m_have = 0; m_granted = 0; m_resp = 0; m_got = '0;
    endtask

    task automatic check_model();
        chk("ex_ready", 32'(ex_ready_o), 32'(!m_have || (m_wbv() && wb_ready_i)));
        chk("mem_req", 32'(mem_req_o), 32'(m_req()));
        chk("wb_valid", 32'(wb_valid_o), 32'(m_wbv()));
        if (m_req()) begin
            chk("mem_addr", mem_addr_o, m_addr - (m_addr % 4));
            chk("mem_we", 32'(mem_we_o), 32'(is_store(m_op)));
            chk("mem_wstrb", 32'(mem_wstrb_o), 32'(exp_strb(m_op, m_addr)));
            chk("mem_wdata", mem_wdata_o, exp_data(m_op, m_wdata));
        end
        if (m_wbv()) begin
            chk("alu_op_o", 32'(alu_op_o), 32'(m_op));
            chk("read_offset", read_offset_o, m_addr % 4);
            chk("rmem_data", rmem_data_o, m_got);
            chk("misalign", 32'(misalign_o), 32'(misal(m_op, m_addr)));
        end
    endtask

    task automatic model_update();
        bit ready;
        if (!rst) begin
            model_reset();
            return;
        end
        ready = !m_have || (m_wbv() && wb_ready_i);
        if (m_req()) begin
            if (mem_gnt_i) m_granted = 1;
        end else if (m_have && m_granted && !m_resp && mem_rvalid_i) begin
            m_resp = 1;
            if (is_load(m_op)) m_got = mem_rdata_i;
        end
        if (ready) begin
            m_have = 0;
            if (ex_valid_i) begin
                m_have = 1; m_granted = 0; m_resp = 0; m_got = '0;
                m_op = alu_op_i; m_addr = addr_i; m_wdata = wdata_i;
            end
        end
    endtask

    task automatic settle();
        #1;
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic offer(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        ex_valid_i = 1'b1; alu_op_i = op; addr_i = a; wdata_i = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 32'(mem_req_o), 0);
        chk({tag, "_we"}, 32'(mem_we_o), 0);
        chk({tag, "_addr"}, mem_addr_o, 0);
        chk({tag, "_wdata"}, mem_wdata_o, 0);
        chk({tag, "_strb"}, 32'(mem_wstrb_o), 0);
        chk({tag, "_wbv"}, 32'(wb_valid_o), 0);
        chk({tag, "_op"}, 32'(alu_op_o), 0);
        chk({tag, "_off"}, read_offset_o, 0);
        chk({tag, "_rmem"}, rmem_data_o, 0);
        chk({tag, "_mis"}, 32'(misalign_o), 0);
    endtask

    localparam int NOPS = 11;
    logic [7:0] op_tab [NOPS] = '{ALU_OP_LB, ALU_OP_LH, ALU_OP_LW, ALU_OP_LBU,
        ALU_OP_LHU, ALU_OP_SB, ALU_OP_SH, ALU_OP_SW, 8'h00, 8'h01, 8'h3F};

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        settle();
        rst = 1'b1;
        settle();
        chk("rst_ex_ready", 32'(ex_ready_o), 1);
        chk_all_zero("rst");
        adv();

        // LW with immediate grant, response next cycle
        offer(ALU_OP_LW, 32'h8000_0004, 32'h0); mem_gnt_i = 1'b1;
        settle(); adv();
        ex_valid_i = 1'b0;
        settle();
        chk("lw_req_n1", 32'(mem_req_o), 1);
        chk("lw_addr", mem_addr_o, 32'h8000_0004);
        adv();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        settle();
        chk("lw_wbv_n2", 32'(wb_valid_o), 0);
        adv();
        mem_rvalid_i = 1'b0; wb_ready_i = 1'b1;
        settle();
        chk("lw_wbv_n3", 32'(wb_valid_o), 1);
        chk("lw_rmem", rmem_data_o, 32'hDEAD_BEEF);
        chk("lw_off", read_offset_o, 0);
        adv();

        // Non-memory op completes one cycle after accept
        offer(8'h01, 32'h0000_0003, 32'h0);
        settle(); adv();
        ex_valid_i = 1'b0;
        settle();
        chk("nop_wbv", 32'(wb_valid_o), 1);
        chk("nop_mis", 32'(misalign_o), 0);
        chk("nop_rmem", rmem_data_o, 0);
        adv();

        // SB with grant held off three cycles, then slow writeback
        wb_ready_i = 1'b0;
        offer(ALU_OP_SB, 32'h8000_0003, 32'h0000_00A5);
        settle(); adv();
        ex_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("sb_req", 32'(mem_req_o), 1);
            chk("sb_strb", 32'(mem_wstrb_o), 32'h8);
            chk("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
            chk("sb_addr", mem_addr_o, 32'h8000_0000);
            chk("sb_we", 32'(mem_we_o), 1);
            adv();
        end
        mem_gnt_i = 1'b1;
        settle(); adv();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        settle(); adv();
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("sb_wbv", 32'(wb_valid_o), 1);
            chk("sb_ex_ready", 32'(ex_ready_o), 0);
            chk("sb_rmem", rmem_data_o, 0);
            chk("sb_op", 32'(alu_op_o), 32'(ALU_OP_SB));
            adv();
        end

        // Back-to-back accept of a misaligned LH while retiring the SB
        wb_ready_i = 1'b1;
        offer(ALU_OP_LH, 32'h8000_0001, 32'h0);
        settle();
        chk("b2b_ex_ready", 32'(ex_ready_o), 1);
        adv();
        ex_valid_i = 1'b0; wb_ready_i = 1'b0;
        settle();
        chk("lh_wbv", 32'(wb_valid_o), 1);
        chk("lh_req", 32'(mem_req_o), 0);
        chk("lh_mis", 32'(misalign_o), 1);
        chk("lh_rmem", rmem_data_o, 0);
        adv();

        // Reset while waiting for a response, then a stray response
        wb_ready_i = 1'b1;
        offer(ALU_OP_LW, 32'h8000_0008, 32'h0);
        settle(); adv();
        ex_valid_i = 1'b0; wb_ready_i = 1'b0; mem_gnt_i = 1'b1;
        settle(); adv();
        mem_gnt_i = 1'b0;
        settle();
        rst = 1'b0;
        model_reset();
        settle();
        chk_all_zero("wrst");
        adv();
        rst = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        settle(); adv();
        mem_rvalid_i = 1'b0;
        settle();
        chk("stray_wbv", 32'(wb_valid_o), 0);
        chk("stray_ex_ready", 32'(ex_ready_o), 1);
        chk("stray_rmem", rmem_data_o, 0);
        adv();

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            ex_valid_i   = ($urandom_range(0, 1) == 1);
            alu_op_i     = op_tab[$urandom_range(0, NOPS - 1)];
            addr_i       = $urandom;
            wdata_i      = $urandom;
            mem_gnt_i    = ($urandom_range(0, 1) == 1);
            mem_rvalid_i = ($urandom_range(0, 4) < 2);
            mem_rdata_i  = $urandom;
            wb_ready_i   = ($urandom_range(0, 4) < 3);
            settle();
            adv();
        end
        ex_valid_i = 1'b0;
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter ALU_OP_W, default 8, width of ALU opcode; equals the shared ALU_OP_BUS width.
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rst  input  1  one clock; reset is asynchronous and active-low (rst==0 resets).
REQ-004 ex_valid_i  input  1  execute offers a memory op.
REQ-005 ex_ready_o  output  1  block accepts the op this cycle.
REQ-006 alu_op_i  input  ALU_OP_W  opcode (LB/LH/LW/LBU/LHU/SB/SH/SW; others = non-memory).
REQ-007 addr_i  input  32  effective byte address.
REQ-008 wdata_i  input  32  store data, right-aligned.
REQ-009 mem_req_o  output  1  data-memory request.
REQ-010 mem_we_o  output  1  1 = write.
REQ-011 mem_addr_o  output  32  word address, {addr[31:2],2'b00}.
REQ-012 mem_wdata_o  output  32  lane-aligned store data.
REQ-013 mem_wstrb_o  output  4  byte write strobes.
REQ-014 mem_gnt_i  input  1  memory accepts request.
REQ-015 mem_rvalid_i  input  1  read data valid / write acknowledge.
REQ-016 mem_rdata_i  input  32  raw read word.
REQ-017 wb_valid_o  output  1  result ready for load-extend/writeback stage.
REQ-018 wb_ready_i  input  1  downstream accepts result.
REQ-019 alu_op_o  output  ALU_OP_W  registered opcode of the op in flight.
REQ-020 read_offset_o  output  32  {30'b0, addr[1:0]} of the op in flight.
REQ-021 rmem_data_o  output  32  captured raw read word (zero for stores/non-memory/misaligned).
REQ-022 misalign_o  output  1  op was misaligned, no memory access made.

Function
REQ-023 FSM states IDLE, REQ, WAIT, DONE SHALL be used; ex_ready_o = (IDLE) or (DONE and wb_ready_i).
REQ-024 On accept, SHALL register alu_op, addr, wdata; memory op aligned -> REQ; non-memory or misaligned -> DONE.
REQ-025 Misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; SHALL set misalign_o=1 in DONE.
REQ-026 In REQ, mem_req_o SHALL be 1 with stable addr/we/wdata/wstrb until mem_gnt_i; gnt -> WAIT.
REQ-027 In WAIT, mem_rvalid_i SHALL capture mem_rdata_i (loads only) and go DONE; mem_req_o=0.
REQ-028 mem_rvalid_i in IDLE, REQ or DONE SHALL be ignored.
REQ-029 In DONE, wb_valid_o=1 with all wb outputs stable until wb_ready_i; then IDLE, or REQ/DONE if a new op is accepted the same cycle.
REQ-030 Strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b0000, we=0.
REQ-031 Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-032 Minimum load latency: accept cycle N, req N+1 (gnt same cycle), rvalid N+2, wb_valid N+3.
REQ-033 Non-memory op: wb_valid_o at N+1, misalign_o=0, rmem_data_o=0.

Reset
REQ-034 rst low SHALL force IDLE immediately; all outputs 0, ex_ready_o 1 after release.
REQ-035 Reset mid-transaction SHALL abandon the op; later rvalid for it is ignored (REQ-028).

Structure
REQ-036 ALU_OP_* codes, ALU_OP_W and ZERO_WORD SHALL come from the shared defines; FSM encoding stays local.
REQ-037 Strobe/data lane generation (REQ-030/031) SHALL be a combinational sub-module store_align.

Verification
REQ-038 LW addr 0x8000_0004, gnt immediate, rvalid next cycle, rdata 0xDEAD_BEEF -> wb_valid at N+3, rmem_data_o 0xDEADBEEF, read_offset_o 0.
REQ-039 SB addr 0x8000_0003, wdata 0x0000_00A5 -> mem_wstrb_o 4'b1000, mem_wdata_o 0xA5A5A5A5, mem_addr_o 0x8000_0000.
REQ-040 LH addr 0x8000_0001 -> no mem_req_o, wb_valid at N+1, misalign_o 1, rmem_data_o 0.
REQ-041 gnt held low 3 cycles -> mem_req_o and request fields stable all 3 cycles.
REQ-042 wb_ready_i low 2 cycles in DONE -> wb outputs stable, ex_ready_o 0; then back-to-back accept.
REQ-043 rst low while in WAIT, then stray rvalid -> outputs 0, state IDLE, rvalid ignored.
